// File: rtl/usb_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : usb_rx_pkg
// Description : Shared USB full-speed receiver timing defaults and helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package usb_rx_pkg;

    localparam int DEF_CLKS_PER_BIT  = 8;
    localparam int DEF_SAMPLE_PT     = 4;
    localparam int DEF_STUFF_LIMIT   = 6;
    localparam int DEF_BITS_PER_BYTE = 8;

    // Bits needed to hold values 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/flex_counter.sv
`default_nettype none
// ============================================================================
// Module      : flex_counter
// Description : Counter 0..rollover_val with clear, count enable and a
//               rollover flag that is high while the count sits at rollover.
// Revision    : 1.0 - initial release
// ============================================================================
module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic                    rollover_flag
);

    logic [NUM_CNT_BITS-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (count_enable) begin
            if (r_count == rollover_val) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + NUM_CNT_BITS'(1);
            end
        end
    end

    assign rollover_flag = (r_count == rollover_val);

endmodule
`default_nettype wire

// File: rtl/usb_rx_timer.sv
`default_nettype none
// ============================================================================
// Module      : usb_rx_timer
// Description : USB FS receive bit timing: edge-tracked sample strobe,
//               bit-unstuffing with stuff-error flag, byte framing.
// Revision    : 1.0 - initial release
// ============================================================================
module usb_rx_timer
    import usb_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT  = DEF_CLKS_PER_BIT,
    parameter int SAMPLE_PT     = DEF_SAMPLE_PT,
    parameter int STUFF_LIMIT   = DEF_STUFF_LIMIT,
    parameter int BITS_PER_BYTE = DEF_BITS_PER_BYTE
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic d_edge,
    input  logic d_orig,
    output logic shift_enable,
    output logic byte_received,
    output logic stuff_err
);

    localparam int c_ph_w   = cnt_width(CLKS_PER_BIT);
    localparam int c_ones_w = cnt_width(STUFF_LIMIT + 1);
    localparam int c_bits_w = cnt_width(BITS_PER_BYTE);

    localparam logic [c_ph_w-1:0]   c_ph_last     = c_ph_w'(CLKS_PER_BIT - 1);
    localparam logic [c_ph_w-1:0]   c_ph_one      = c_ph_w'(1);
    localparam logic [c_ph_w-1:0]   c_sample_pt   = c_ph_w'(SAMPLE_PT);
    localparam logic [c_ones_w-1:0] c_stuff_limit = c_ones_w'(STUFF_LIMIT);
    localparam logic [c_bits_w-1:0] c_bits_last   = c_bits_w'(BITS_PER_BYTE - 1);

    logic [c_ph_w-1:0]   r_ph;
    logic [c_ph_w-1:0]   w_ph_next;
    logic [c_ones_w-1:0] r_ones;
    logic [c_ones_w-1:0] w_ones_next;
    logic                w_sample;
    logic                w_stuffed;
    logic                w_clear;
    logic                w_bits_roll;
    logic                r_byte_received;
    logic                r_stuff_err;

    always_comb begin
        w_sample     = enable && (r_ph == c_sample_pt);
        w_stuffed    = w_sample && (r_ones == c_stuff_limit);
        shift_enable = w_sample && !w_stuffed;
        w_clear      = !enable;

        // An edge re-centres the bit: the edge cycle itself counts as phase 0.
        if (d_edge || !enable) begin
            w_ph_next = c_ph_one;
        end else if (r_ph == c_ph_last) begin
            w_ph_next = '0;
        end else begin
            w_ph_next = r_ph + c_ph_w'(1);
        end

        w_ones_next = r_ones;
        if (!enable) begin
            w_ones_next = '0;
        end else if (w_sample) begin
            if (w_stuffed || !d_orig) begin
                w_ones_next = '0;
            end else begin
                w_ones_next = r_ones + c_ones_w'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ph            <= '0;
            r_ones          <= '0;
            r_byte_received <= 1'b0;
            r_stuff_err     <= 1'b0;
        end else begin
            r_ph            <= w_ph_next;
            r_ones          <= w_ones_next;
            r_byte_received <= enable && shift_enable && w_bits_roll;
            r_stuff_err     <= enable && w_stuffed && d_orig;
        end
    end

    flex_counter #(
        .NUM_CNT_BITS (c_bits_w)
    ) u_bit_cnt (
        .clk           (clk),
        .rst           (rst),
        .clear         (w_clear),
        .count_enable  (shift_enable),
        .rollover_val  (c_bits_last),
        .rollover_flag (w_bits_roll)
    );

    assign byte_received = r_byte_received;
    assign stuff_err     = r_stuff_err;

endmodule
`default_nettype wire

// File: tb/tb_usb_rx_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_usb_rx_timer
// Description : Self-checking bench for usb_rx_timer (bit-level vector table
//               plus hand-written resync, reset and abort sequences).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_usb_rx_timer;

    logic clk = 1'b0;
    logic rst;
    logic enable;
    logic d_edge;
    logic d_orig;
    logic shift_enable;
    logic byte_received;
    logic stuff_err;

    always #5 clk = ~clk;

    usb_rx_timer dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .d_edge        (d_edge),
        .d_orig        (d_orig),
        .shift_enable  (shift_enable),
        .byte_received (byte_received),
        .stuff_err     (stuff_err)
    );

    // One record per USB bit time; expectations hold at sample+0 / sample+1.
    typedef struct {
        bit start;
        bit d;
        bit x_shift;
        bit x_byte;
        bit x_err;
    } vec_t;

    typedef struct {
        bit s;
        bit b;
        bit e;
    } exp_t;

    vec_t  vecs[$];
    exp_t  sb[$];
    int    n_checks = 0;
    int    n_errors = 0;
    int    g_cyc    = 0;
    string g_tag    = "init";

    function automatic void check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s %s cyc=%0d: got %b, want %b", g_tag, name, g_cyc, act, exp);
        end
    endfunction

    function automatic void add(input bit st, input bit d, input bit xs, input bit xb, input bit xe);
        vec_t v;
        v.start = st; v.d = d; v.x_shift = xs; v.x_byte = xb; v.x_err = xe;
        vecs.push_back(v);
    endfunction

    task automatic drive_cycle(input bit en, input bit ed, input bit d,
                               input bit xs, input bit xb, input bit xe);
        exp_t x;
        @(negedge clk);
        enable = en;
        d_edge = ed;
        d_orig = d;
        sb.push_back('{s: xs, b: xb, e: xe});
        #1;
        x = sb.pop_front();
        check1("shift_enable", shift_enable, x.s);
        check1("byte_received", byte_received, x.b);
        check1("stuff_err", stuff_err, x.e);
        g_cyc++;
    endtask

    // Eight clocks of one bit: edge at clock 0 only for a 0 (or a stream start),
    // sample at clock 4, registered pulses at clock 5.
    task automatic run_bit(input bit first, input vec_t v);
        for (int c = 0; c < 8; c++) begin
            drive_cycle(!(first && c == 0),
                        (c == 0) && (first || !v.d),
                        v.d,
                        (c == 4) && v.x_shift,
                        (c == 5) && v.x_byte,
                        (c == 5) && v.x_err);
        end
    endtask

    vec_t z_shift;
    vec_t z_last;

    initial begin
        // Clean stream, two bytes
        add(1, 0, 1, 0, 0);
        for (int i = 1; i < 7; i++) add(0, 0, 1, 0, 0);
        add(0, 0, 1, 1, 0);
        add(0, 1, 1, 0, 0); add(0, 0, 1, 0, 0); add(0, 1, 1, 0, 0); add(0, 1, 1, 0, 0);
        add(0, 0, 1, 0, 0); add(0, 0, 1, 0, 0); add(0, 1, 1, 0, 0); add(0, 0, 1, 1, 0);
        // Six ones, stuffed 0 dropped, byte after nine bit times
        add(1, 1, 1, 0, 0);
        for (int i = 1; i < 6; i++) add(0, 1, 1, 0, 0);
        add(0, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0); add(0, 0, 1, 1, 0);
        // Seven ones: stuff error, framing continues
        add(1, 1, 1, 0, 0);
        for (int i = 1; i < 6; i++) add(0, 1, 1, 0, 0);
        add(0, 1, 0, 0, 1);
        add(0, 0, 1, 0, 0); add(0, 0, 1, 1, 0);
        // Five ones broken by a 0: no stuffing
        add(1, 1, 1, 0, 0);
        for (int i = 1; i < 5; i++) add(0, 1, 1, 0, 0);
        add(0, 0, 1, 0, 0); add(0, 1, 1, 0, 0); add(0, 1, 1, 1, 0);

        z_shift = '{start: 0, d: 0, x_shift: 1, x_byte: 0, x_err: 0};
        z_last  = '{start: 0, d: 0, x_shift: 1, x_byte: 1, x_err: 0};

        rst = 1'b1; enable = 1'b0; d_edge = 1'b0; d_orig = 1'b0;
        @(negedge clk); @(negedge clk);
        #1;
        g_tag = "reset";
        check1("shift_enable", shift_enable, 1'b0);
        check1("byte_received", byte_received, 1'b0);
        check1("stuff_err", stuff_err, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        g_tag = "table";
        foreach (vecs[i]) begin
            g_cyc = 0;
            run_bit(vecs[i].start, vecs[i]);
        end

        // Second edge two clocks late: sampling follows it
        g_tag = "resync";
        g_cyc = 0;
        for (int c = 0; c <= 66; c++) begin
            drive_cycle(c != 0,
                        (c == 0) || (c >= 10 && (c - 10) % 8 == 0),
                        1'b0,
                        (c == 4) || (c >= 14 && (c - 14) % 8 == 0),
                        c == 63,
                        1'b0);
        end

        // Async reset while shift_enable is high, three bits into a byte
        g_tag = "rst_mid";
        g_cyc = 0;
        run_bit(1, z_shift); run_bit(0, z_shift); run_bit(0, z_shift);
        for (int c = 0; c < 5; c++) drive_cycle(1, c == 0, 0, c == 4, 0, 0);
        #1 rst = 1'b1;
        #1;
        check1("async_shift_enable", shift_enable, 1'b0);
        check1("async_byte_received", byte_received, 1'b0);
        check1("async_stuff_err", stuff_err, 1'b0);
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 12; c++) drive_cycle(0, c % 3 == 0, c[0], 0, 0, 0);

        // Abort after five shifts (enable drops on a sample), then full new byte
        g_tag = "abort";
        g_cyc = 0;
        run_bit(1, z_shift);
        for (int i = 0; i < 4; i++) run_bit(0, z_shift);
        for (int c = 0; c < 6; c++) drive_cycle(c < 4, c == 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            vec_t v;
            v = (i == 7) ? z_last : z_shift;
            run_bit(i == 0, v);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
